midi_tx_encoder: RTL
====================

// Module: midi_tx_encoder
// PURPOSE
//  Encodes channel-voice and system real-time events into MIDI bytes and serialises them as 31250-baud 8N1 UART on midi_txd.
//  Transmit counterpart of the synth's MIDI receive/decode path; fed by the SoC bridge or the synth controller (echo/thru, patch dump).
//  Applies running status to drop repeated status bytes; one event in flight, valid/ready handshake.
// PARAMETERS
//  CLK_HZ        50_000_000  CLOCK_50 frequency
//  BAUD          31250       MIDI bit rate; BIT_CYC = CLK_HZ/BAUD (1600)
//  RUNNING_STAT  1           1 = enable running-status suppression
//  RS_IDLE_CYC   15_000_000  idle clocks after which running status is forgotten (300 ms)
// PORTS
//  CLOCK_50     in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  ev_valid     in   1  event offered
//  ev_ready     out  1  encoder accepts event this cycle
//  ev_status    in   8  status byte (bit7 must be 1)
//  ev_data1     in   7  first data byte
//  ev_data2     in   7  second data byte (ignored for 2-byte messages)
//  ev_drop      out  1  1-cycle pulse: offered event rejected (status bit7 = 0)
//  busy         out  1  frame in progress
//  midi_txd     out  1  serial out, idle high
// BEHAVIOUR
//  Reset: midi_txd=1, ev_ready=1, busy=0, ev_drop=0, running status cleared, all counters 0.
//  Handshake: transfer when ev_valid&&ev_ready; ev_ready=1 only in IDLE. Inputs latched on transfer.
//  Rejection: ev_valid&&ev_ready with ev_status[7]=0 -> ev_drop pulses next cycle, nothing sent, stay IDLE.
//  Message length from status: 8x,9x,Ax,Bx,Ex -> 3 bytes; Cx,Dx -> 2 bytes; F0-FF -> 1 byte.
//  Running status (RUNNING_STAT=1): status byte omitted when ev_status[7:4] in 8-E and equals last sent channel status.
//   Channel status send -> stored as running status. F0-F7 send -> running status cleared. F8-FF -> unchanged.
//   Line idle (IDLE, no transfer) for RS_IDLE_CYC consecutive cycles -> running status cleared.
//  FSM: IDLE -> SEND_STATUS (skipped if suppressed or not needed) -> SEND_D1 -> SEND_D2 (3-byte only) -> IDLE.
//   Each SEND_* hands one byte to the UART and waits for byte_done.
//  Frame: start(0), 8 data bits LSB first, stop(1); each bit held exactly BIT_CYC cycles; 10*BIT_CYC per byte.
//  Latency: midi_txd falls on the cycle after transfer. Bytes of one message are back-to-back, no idle gap.
//  ev_ready returns high the cycle after the last stop bit ends (3-byte msg: 30*BIT_CYC cycles after transfer).
//  busy=1 from the first start bit to the end of the last stop bit.
//  Data bytes sent as {1'b0, ev_dataN}; bit7 always 0.
//  Reset mid-frame: midi_txd=1 the cycle after reset; no partial byte resumed; running status cleared.
//  Baud counter wraps at BIT_CYC-1; bit counter 0..9; no drift across frames.
// STRUCTURE
//  Shared package midi_pkg: status-nibble constants (NOTE_OFF..PITCH_BEND, SYS), function msg_len(status) -> 1..3,
//   function is_realtime(status).
//  Sub-module midi_uart_tx: byte_valid/byte_ready/byte_in -> midi_txd, byte_done pulse; owns baud and bit counters.
//  Top: encoder FSM, running-status register, idle timer.
// TESTING (BIT_CYC=1600)
//  1. 0x90,0x3C,0x64 after reset -> frames 0x90,0x3C,0x64 LSB first; ev_ready low 48000 cycles.
//  2. Repeat 0x90,0x3C,0x00 -> only 0x3C,0x00 sent (20 bit times); ev_ready low 32000 cycles.
//  3. 0xF8 between two 0x91 notes -> single 0xF8 frame; the second 0x91 omits status.
//  4. 0xC5,0x10,(0x7F) -> 2 frames 0xC5,0x10; ev_data2 not sent; then 0x90 -> status byte sent.
//  5. Idle RS_IDLE_CYC cycles after 0x90 msg, then 0x90 again -> status byte re-sent (3 frames).
//  6. Reset at bit 4 of a frame -> midi_txd=1, ev_ready=1 next cycle; next 0x90 msg sends status.
//  7. ev_status=0x3C offered -> ev_drop pulses 1 cycle, midi_txd stays 1, ev_ready stays 1.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status-nibble codes, encoder state type, message-length helpers.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] POLY_AT    = 4'hA;
    localparam logic [3:0] CTRL_CHG   = 4'hB;
    localparam logic [3:0] PROG_CHG   = 4'hC;
    localparam logic [3:0] CHAN_AT    = 4'hD;
    localparam logic [3:0] PITCH_BEND = 4'hE;
    localparam logic [3:0] SYS        = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_STATUS,
        S_SEND_D1,
        S_SEND_D2
    } enc_state_t;

    // Total bytes on the wire for a message, status byte included.
    function automatic logic [1:0] msg_len(input logic [7:0] status);
        logic [1:0] len;
        case (status[7:4])
            PROG_CHG, CHAN_AT: len = 2'd2;
            SYS:               len = 2'd1;
            default:           len = 2'd3;
        endcase
        return len;
    endfunction

    function automatic logic is_realtime(input logic [7:0] status);
        return status[7:3] == 5'b11111;
    endfunction

    function automatic logic is_channel(input logic [7:0] status);
        return status[7] && (status[7:4] != SYS);
    endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// 8N1 serialiser: one byte per 10 bit times, LSB first; a new byte may be
// loaded in the last cycle of the stop bit so consecutive frames have no gap.
module midi_uart_tx #(
    parameter int BIT_CYC = 1600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_in,
    output logic       byte_done,
    output logic       busy,
    output logic       txd
);
    localparam int BW = $clog2(BIT_CYC);

    logic          active_q, active_d;
    logic          txd_q, txd_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shift_q, shift_d;
    logic          bit_end;

    assign bit_end    = active_q && (baud_q == BW'(BIT_CYC - 1));
    assign byte_done  = bit_end && (bit_q == 4'd9);
    assign byte_ready = !active_q || byte_done;
    assign busy       = active_q;
    assign txd        = txd_q;

    always_comb begin
        active_d = active_q;
        txd_d    = txd_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        if (active_q) begin
            if (bit_end) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    txd_d    = 1'b1;
                    bit_d    = '0;
                end else begin
                    // a 1 is shifted in behind the data so the stop bit falls out last
                    bit_d   = bit_q + 4'd1;
                    txd_d   = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
        if (byte_valid && byte_ready) begin
            active_d = 1'b1;
            txd_d    = 1'b0;
            baud_d   = '0;
            bit_d    = '0;
            shift_d  = {1'b1, byte_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            txd_q    <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
        end else begin
            active_q <= active_d;
            txd_q    <= txd_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

endmodule

// File: rtl/midi_tx_encoder.sv
// MIDI event encoder: running-status suppression, idle forget timer, byte sequencing
// into the UART. First start bit the cycle after acceptance; ev_ready low until last stop bit ends.
module midi_tx_encoder
    import midi_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 31250,
    parameter int RUNNING_STAT = 1,
    parameter int RS_IDLE_CYC  = 15_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [7:0] ev_status,
    input  logic [6:0] ev_data1,
    input  logic [6:0] ev_data2,
    output logic       ev_drop,
    output logic       busy,
    output logic       midi_txd
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int IW      = $clog2(RS_IDLE_CYC + 1);

    enc_state_t    state_q, state_d;
    logic [1:0]    len_q, len_d;
    logic [6:0]    d1_q, d1_d, d2_q, d2_d;
    logic [7:0]    rs_q, rs_d;
    logic          rs_vld_q, rs_vld_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          drop_q, drop_d;
    logic          byte_vld, byte_rdy, byte_done;
    logic [7:0]    byte_dat;
    logic          xfer, suppress;

    assign ev_ready = (state_q == S_IDLE) && byte_rdy;
    assign xfer     = ev_valid && ev_ready;
    assign suppress = (RUNNING_STAT != 0) && rs_vld_q && is_channel(ev_status)
                      && (ev_status == rs_q);
    assign ev_drop  = drop_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        rs_d     = rs_q;
        rs_vld_d = rs_vld_q;
        idle_d   = '0;
        drop_d   = 1'b0;
        byte_vld = 1'b0;
        byte_dat = {1'b0, d1_q};

        if (state_q == S_IDLE && !xfer) begin
            if (idle_q == IW'(RS_IDLE_CYC - 1)) rs_vld_d = 1'b0;
            else                                idle_d   = idle_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (!ev_status[7]) begin
                        drop_d = 1'b1;
                    end else begin
                        len_d    = msg_len(ev_status);
                        d1_d     = ev_data1;
                        d2_d     = ev_data2;
                        byte_vld = 1'b1;
                        if (suppress) begin
                            byte_dat = {1'b0, ev_data1};
                            state_d  = S_SEND_D1;
                        end else begin
                            byte_dat = ev_status;
                            state_d  = S_SEND_STATUS;
                        end
                        // realtime bytes may interleave without disturbing running status
                        if (is_channel(ev_status)) begin
                            rs_d     = ev_status;
                            rs_vld_d = 1'b1;
                        end else if (!is_realtime(ev_status)) begin
                            rs_vld_d = 1'b0;
                        end
                    end
                end
            end
            S_SEND_STATUS: begin
                if (byte_done) begin
                    if (len_q == 2'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        byte_vld = 1'b1;
                        byte_dat = {1'b0, d1_q};
                        state_d  = S_SEND_D1;
                    end
                end
            end
            S_SEND_D1: begin
                if (byte_done) begin
                    if (len_q == 2'd3) begin
                        byte_vld = 1'b1;
                        byte_dat = {1'b0, d2_q};
                        state_d  = S_SEND_D2;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_SEND_D2: begin
                if (byte_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            rs_q     <= '0;
            rs_vld_q <= 1'b0;
            idle_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            rs_q     <= rs_d;
            rs_vld_q <= rs_vld_d;
            idle_q   <= idle_d;
            drop_q   <= drop_d;
        end
    end

    midi_uart_tx #(
        .BIT_CYC(BIT_CYC)
    ) u_uart (
        .clk        (CLOCK_50),
        .reset      (reset),
        .byte_valid (byte_vld),
        .byte_ready (byte_rdy),
        .byte_in    (byte_dat),
        .byte_done  (byte_done),
        .busy       (busy),
        .txd        (midi_txd)
    );

endmodule
